// File: rtl/mmio_uart_tx_responder_if.sv
// Data-bus view shared by the core (master) and the UART TX responder (slave).
interface mmio_uart_tx_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, hit
  );
endinterface

// File: rtl/mmio_uart_tx_responder.sv
// Memory-mapped UART transmitter: stores to TXDATA fill a TX FIFO drained by a serial FSM.
// Optional even-parity bit is compiled in with macro UART_TX_PARITY_EN.
module mmio_uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [15:0] CLKS_PER_BIT = 16'd16,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  mmio_uart_tx_responder_if.slave    bus,
  output logic                       tx,
  output logic                       tx_busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
  localparam logic PARITY_PRESENT = 1'b0;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   bit_div_q, bit_div_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   baud_q, baud_d;

  logic          wr_en, push_req, push_ok, pop, full, empty, bit_end;
  logic [1:0]    offset;
  logic [15:0]   eff_div;
  logic          unused_bits;

  assign unused_bits = ^{bus.Address[1:0], bus.WriteData[DATA_WIDTH-1:16]};

  assign bus.hit  = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign offset   = bus.Address[3:2];
  assign wr_en    = bus.hit && bus.MemWrite;
  assign push_req = wr_en && (offset == 2'd0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign tx_busy  = (state_q != ST_IDLE) || !empty;
  assign eff_div  = (baud_q == '0) ? 16'd1 : baud_q;
  assign bit_end  = (cnt_q == bit_div_q - 16'd1);
  // A full FIFO still accepts a push when the FSM pops in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    bus.ReadData = '0;
    if (bus.hit && bus.MemRead) begin
      case (offset)
        2'd1:    bus.ReadData[4:0]  = {PARITY_PRESENT, overflow_q, tx_busy, empty, full};
        2'd2:    bus.ReadData[15:0] = baud_q;
        default: bus.ReadData = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_div_d = bit_div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    pop       = 1'b0;
    tx        = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = fifo_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_q[rd_ptr_q];
`endif
          bit_div_d = eff_div;
          cnt_d     = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx = parity_q;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      ST_STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (wr_en && (offset == 2'd1) && bus.WriteData[3]) overflow_d = 1'b0;
    if (push_req && full && !pop) overflow_d = 1'b1;
    baud_d     = baud_q;
    if (wr_en && (offset == 2'd2)) baud_d = bus.WriteData[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_div_q  <= 16'd1;
      bit_idx_q  <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_q     <= CLKS_PER_BIT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_div_q  <= bit_div_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      baud_q     <= baud_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push_ok) fifo_q[wr_ptr_q] <= bus.WriteData[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx_responder.sv
// Directed self-checking bench for mmio_uart_tx_responder; tx is logged every cycle
// shortly after the clock edge and frames are checked against the bench's own bit model.
module tb_mmio_uart_tx_responder;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [31:0] PAR_BIT = 32'h10;
`else
  localparam int NBITS = 10;
  localparam logic [31:0] PAR_BIT = 32'h0;
`endif
  localparam logic [31:0] A_TX   = 32'h1001_0000;
  localparam logic [31:0] A_STAT = 32'h1001_0004;
  localparam logic [31:0] A_BAUD = 32'h1001_0008;
  localparam logic [31:0] A_RSV  = 32'h1001_000C;
  localparam int LOGN = 4096;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, tx_busy;
  int   checks = 0;
  int   failures = 0;
  int   n = 0;
  logic tx_log [LOGN];

  mmio_uart_tx_responder_if #(.DATA_WIDTH(32)) bus ();

  mmio_uart_tx_responder #(
    .BASE_ADDR(32'h1001_0000), .FIFO_DEPTH(4), .CLKS_PER_BIT(16'd16), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (n < LOGN) tx_log[n] = tx;
    n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.Address = a; bus.WriteData = d; bus.MemWrite = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.MemWrite = 1'b0; bus.WriteData = '0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a; bus.MemRead = 1'b1;
    #1;
    d = bus.ReadData;
    bus.MemRead = 1'b0;
  endtask

  task automatic wait_log(input int idx);
    for (int i = 0; i < 2000 && n <= idx; i++) @(negedge clk);
    chk("log_reached", {31'b0, n > idx}, 32'h1);
  endtask

  task automatic check_frame(input string tag, input int pos, input logic [7:0] b, input int div);
    for (int j = 0; j < NBITS; j++) begin
      logic e;
      if (j == 0) e = 1'b0;
      else if (j <= 8) e = b[j-1];
      else if (j == 9 && NBITS == 11) e = ^b;
      else e = 1'b1;
      for (int k = 0; k < div; k++)
        chk($sformatf("%s_bit%0d_c%0d", tag, j, k), {31'b0, tx_log[pos + j*div + k]}, {31'b0, e});
    end
  endtask

  initial begin
    logic [31:0] rd;
    int n0, zeros;
    bus.Address = A_TX; bus.WriteData = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;

    // 1: reset and register read-back
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_busy", {31'b0, tx_busy}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    load(A_STAT, rd); chk("rst_status", rd, 32'h2);
    load(A_BAUD, rd); chk("rst_baud", rd, 32'd16);
    load(A_TX, rd);   chk("txdata_reads0", rd, 32'h0);
    load(A_RSV, rd);  chk("reserved_reads0", rd, 32'h0);
    bus.Address = 32'h1001_000F; #1; chk("hit_top", {31'b0, bus.hit}, 32'h1);
    chk("no_memread_rd0", bus.ReadData, 32'h0);
    load(32'h1002_0004, rd); chk("miss_rd0", rd, 32'h0);
    chk("miss_hit", {31'b0, bus.hit}, 32'h0);
    bus.Address = 32'h1000_FFFC; #1; chk("miss_below", {31'b0, bus.hit}, 32'h0);

    // 2: single frame 0xA5 at divider 4, latency and end of busy
    store(A_BAUD, 32'h4);
    store(A_TX, 32'hA5); n0 = n;
    idle();
    chk("t2_busy_queued", {31'b0, tx_busy}, 32'h1);
    load(A_BAUD, rd); chk("t2_baud", rd, 32'h4);
    wait_log(n0 + 1 + NBITS*4);
    chk("t2_idle_after_push", {31'b0, tx_log[n0]}, 32'h1);
    check_frame("t2", n0 + 1, 8'hA5, 4);
    chk("t2_idle_after", {31'b0, tx_log[n0 + 1 + NBITS*4]}, 32'h1);
    @(negedge clk);
    chk("t2_busy_done", {31'b0, tx_busy}, 32'h0);
    load(A_STAT, rd); chk("t2_status", rd, 32'h2 | PAR_BIT);

    // 3: five back-to-back bytes at divider 2, one idle cycle between frames
    store(A_BAUD, 32'h2);
    store(A_TX, 32'h11); n0 = n;
    store(A_TX, 32'h22);
    store(A_TX, 32'h33);
    store(A_TX, 32'h44);
    store(A_TX, 32'h55);
    idle();
    load(A_STAT, rd); chk("t3_no_overflow", rd & 32'h8, 32'h0);
    wait_log(n0 + 1 + 5*(NBITS*2 + 1));
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'h11 * 8'(i + 1);
      check_frame($sformatf("t3_f%0d", i), n0 + 1 + i*(NBITS*2 + 1), b, 2);
      chk($sformatf("t3_gap%0d", i), {31'b0, tx_log[n0 + 1 + i*(NBITS*2 + 1) + NBITS*2]}, 32'h1);
    end

    // 4: overflow with six pushes at divider 8, then write-1-to-clear
    store(A_BAUD, 32'h8);
    store(A_TX, 32'h61); n0 = n;
    store(A_TX, 32'h62);
    store(A_TX, 32'h63);
    store(A_TX, 32'h64);
    store(A_TX, 32'h65);
    store(A_TX, 32'h66);
    idle();
    load(A_STAT, rd); chk("t4_status_full_ovf", rd, 32'hD | PAR_BIT);
    store(A_STAT, 32'h8);
    idle();
    load(A_STAT, rd); chk("t4_status_cleared", rd, 32'h5 | PAR_BIT);
    wait_log(n0 + 5*(NBITS*8 + 1) + 20);
    for (int i = 0; i < 5; i++)
      check_frame($sformatf("t4_f%0d", i), n0 + 1 + i*(NBITS*8 + 1), 8'h61 + 8'(i), 8);
    zeros = 0;
    for (int i = n0 + 1 + 5*(NBITS*8 + 1); i <= n0 + 5*(NBITS*8 + 1) + 20; i++)
      if (tx_log[i] !== 1'b1) zeros++;
    chk("t4_sixth_dropped", zeros, 0);
    chk("t4_busy_done", {31'b0, tx_busy}, 32'h0);

    // 5: reset during data bit 3 with two bytes queued
    store(A_BAUD, 32'h4);
    store(A_TX, 32'hF0); n0 = n;
    store(A_TX, 32'h5A);
    store(A_TX, 32'h77);
    idle();
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_in_bit3", {31'b0, tx_log[n0 + 17]}, 32'h0);
    chk("t5_tx", {31'b0, tx}, 32'h1);
    chk("t5_busy", {31'b0, tx_busy}, 32'h0);
    reset = 1'b1;
    load(A_STAT, rd); chk("t5_status", rd, 32'h2 | PAR_BIT);
    load(A_BAUD, rd); chk("t5_baud", rd, 32'd16);
    wait_log(n0 + 80);
    zeros = 0;
    for (int i = n0 + 18; i <= n0 + 80; i++)
      if (tx_log[i] !== 1'b1) zeros++;
    chk("t5_no_frames", zeros, 0);

    // 6: divider 1 with byte 0x07, then divider 0 behaving as 1
    store(A_BAUD, 32'h1);
    store(A_TX, 32'h07); n0 = n;
    idle();
    load(A_STAT, rd); chk("t6_parity_flag", rd & 32'h10, PAR_BIT);
    wait_log(n0 + 1 + NBITS);
    check_frame("t6", n0 + 1, 8'h07, 1);
    chk("t6_idle_after", {31'b0, tx_log[n0 + 1 + NBITS]}, 32'h1);
    store(A_BAUD, 32'h0);
    store(A_TX, 32'h80); n0 = n;
    idle();
    load(A_BAUD, rd); chk("t6_baud0_raw", rd, 32'h0);
    wait_log(n0 + 1 + NBITS);
    check_frame("t6_div0", n0 + 1, 8'h80, 1);
    chk("t6_div0_idle", {31'b0, tx_log[n0 + 1 + NBITS]}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
